// File: rtl/compressor_bist_ctrl.sv
`default_nettype none
//==============================================================================
// Module      : compressor_bist_ctrl
// Description : BIST sequencer for a 4:2 compressor. It walks a synchronous
//               vector ROM, drives each stimulus, checks the compressor
//               response and reports pass/fail with saturating error counts.
//               Optional first-failure log enabled by macro BIST_FAIL_LOG_EN.
// Revision    : 1.0 - initial release
//==============================================================================
module compressor_bist_ctrl #(
    parameter int NUM_VECTORS = 32,
    parameter int ADDR_W      = 5,
    parameter int ERR_W       = 7
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic [ADDR_W-1:0] vec_addr,
    input  logic [7:0]        vec_data,
    output logic              dut_cin,
    output logic [3:0]        dut_i,
    input  logic              dut_c,
    input  logic              dut_cout,
    input  logic              dut_s,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic [ADDR_W:0]   vec_count
`ifdef BIST_FAIL_LOG_EN
    ,
    output logic              fail_valid,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        fail_obs
`endif
);

    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(NUM_VECTORS - 1);
    localparam logic [ERR_W-1:0]  c_ERR_MAX   = '1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_APPLY = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [ADDR_W-1:0] r_vec_addr;
    logic              r_dut_cin;
    logic [3:0]        r_dut_i;
    logic [2:0]        r_expected;
    logic [ERR_W-1:0]  r_err_count;
    logic [ADDR_W:0]   r_vec_count;
    logic              r_busy;
    logic              r_done;

    logic              w_launch;
    logic              w_last;
    logic              w_mismatch;
    logic [2:0]        w_observed;

    assign w_observed = {dut_c, dut_cout, dut_s};
    assign w_launch   = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last     = (r_vec_addr == c_LAST_ADDR);
    assign w_mismatch = (w_observed != r_expected);

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE:  if (start) w_state_next = S_FETCH;
            S_FETCH: w_state_next = S_APPLY;
            S_APPLY: w_state_next = S_CHECK;
            S_CHECK: w_state_next = w_last ? S_DONE : S_FETCH;
            S_DONE:  if (start) w_state_next = S_FETCH;
            default: w_state_next = S_IDLE;
        endcase
    end

    // done is delayed one cycle behind entry to DONE, so it rises
    // 3*NUM_VECTORS+1 edges after the edge that sampled start.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_vec_addr  <= '0;
            r_dut_cin   <= 1'b0;
            r_dut_i     <= '0;
            r_expected  <= '0;
            r_err_count <= '0;
            r_vec_count <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next == S_FETCH) || (w_state_next == S_APPLY) ||
                       (w_state_next == S_CHECK);
            r_done  <= (r_state == S_DONE) && (w_state_next == S_DONE);

            if (w_launch) begin
                r_vec_addr  <= '0;
                r_err_count <= '0;
                r_vec_count <= '0;
            end

            if (r_state == S_APPLY) begin
                r_dut_cin  <= vec_data[7];
                r_dut_i    <= vec_data[6:3];
                r_expected <= vec_data[2:0];
            end

            if (r_state == S_CHECK) begin
                r_vec_count <= r_vec_count + 1'b1;
                if (w_mismatch && (r_err_count != c_ERR_MAX)) begin
                    r_err_count <= r_err_count + 1'b1;
                end
                if (!w_last) begin
                    r_vec_addr <= r_vec_addr + 1'b1;
                end
            end
        end
    end

`ifdef BIST_FAIL_LOG_EN
    logic              r_fail_valid;
    logic [ADDR_W-1:0] r_fail_addr;
    logic [2:0]        r_fail_obs;

    // Only the first mismatch of a run is kept.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_fail_valid <= 1'b0;
            r_fail_addr  <= '0;
            r_fail_obs   <= '0;
        end else if (w_launch) begin
            r_fail_valid <= 1'b0;
            r_fail_addr  <= '0;
            r_fail_obs   <= '0;
        end else if ((r_state == S_CHECK) && w_mismatch && !r_fail_valid) begin
            r_fail_valid <= 1'b1;
            r_fail_addr  <= r_vec_addr;
            r_fail_obs   <= w_observed;
        end
    end

    assign fail_valid = r_fail_valid;
    assign fail_addr  = r_fail_addr;
    assign fail_obs   = r_fail_obs;
`endif

    assign vec_addr  = r_vec_addr;
    assign dut_cin   = r_dut_cin;
    assign dut_i     = r_dut_i;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_done && (r_err_count == '0);
    assign err_count = r_err_count;
    assign vec_count = r_vec_count;

endmodule
`default_nettype wire
